// File: rtl/encoder4to2_serial_if.sv
// Handshake bundle for encoder4to2_serial: request vector in, one encoded index out per transfer.
interface encoder4to2_serial_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] D;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Y;
   logic         last;
   logic         none;

   // Producer/consumer side (drives requests, accepts indices)
   modport master (
      output in_valid, D, out_ready,
      input  in_ready, out_valid, Y, last, none
   );

   // Encoder side
   modport slave (
      input  in_valid, D, out_ready,
      output in_ready, out_valid, Y, last, none
   );
endinterface

// File: rtl/encoder4to2_serial.sv
// Sequential priority encoder: captures a multi-hot vector and emits one set-bit index per handshake.
// Optional macro ENC_MSB_FIRST_EN selects highest-first order instead of the default lowest-first.
module encoder4to2_serial #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   encoder4to2_serial_if.slave   bus
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic         none_q, none_d;
   logic [W-1:0] sel;
   logic         single;

   // Pick the next index to emit from the outstanding request bits
   always_comb begin
      sel = '0;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 0; i < int'(N); i++) begin
         if (pending_q[i]) sel = W'(i);
      end
`else
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (pending_q[i]) sel = W'(i);
      end
`endif
   end

   // Exactly one bit outstanding means the current index closes the vector
   assign single = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         none_q    <= none_d;
      end
   end

   // Next-state and handshake decode; outputs depend only on registered state
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      none_d        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.Y         = '0;
      bus.last      = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               if (bus.D != '0) begin
                  pending_d = bus.D;
                  state_d   = DRAIN;
               end else begin
                  none_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            bus.out_valid = 1'b1;
            bus.Y         = sel;
            bus.last      = single;
            if (bus.out_ready) begin
               pending_d = pending_q & ~(N'(1) << sel);
               if (single) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.none = none_q;

endmodule

// File: tb/tb_encoder4to2_serial.sv
// Scoreboard bench for encoder4to2_serial: directed cases from the plan plus randomized traffic.
module tb_encoder4to2_serial;
   localparam int unsigned N = 4;
   localparam int unsigned W = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   encoder4to2_serial_if #(.N(N), .W(W)) bus ();
   encoder4to2_serial #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [W:0] exp_q[$];  // {last, index}
   logic       exp_none = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: every set bit of d, in emission order, last flag on the final one
   function automatic void push_vec(input logic [N-1:0] d);
      int idx[$];
      for (int i = 0; i < int'(N); i++) if (d[i]) idx.push_back(i);
`ifdef ENC_MSB_FIRST_EN
      idx.reverse();
`endif
      foreach (idx[k]) exp_q.push_back({1'(k == idx.size() - 1), W'(idx[k])});
   endfunction

   // One clock of stimulus; expectations are pushed after the accepting edge
   task automatic step(input logic iv, input logic [N-1:0] d, input logic ordy);
      logic acc;
      bus.in_valid  = iv;
      bus.D         = d;
      bus.out_ready = ordy;
      @(negedge clk);
      acc = iv && bus.in_ready;
      @(posedge clk);
      #1;
      exp_none = acc && (d == '0);
      if (acc && d != '0) push_vec(d);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         step(1'b0, '0, 1'b1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      step(1'b0, '0, 1'b1);
   endtask

   // Monitor: compares DUT outputs against the scoreboard every cycle
   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
         check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
         check("none", 32'(bus.none), 32'(exp_none));
         if (exp_q.size() != 0) begin
            check("Y", 32'(bus.Y), 32'(exp_q[0][W-1:0]));
            check("last", 32'(bus.last), 32'(exp_q[0][W]));
            if (bus.out_ready) void'(exp_q.pop_front());
         end else begin
            check("idle_Y", 32'(bus.Y), 32'(0));
            check("idle_last", 32'(bus.last), 32'(0));
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_Y", 32'(bus.Y), 32'(0));
      check("rst_last", 32'(bus.last), 32'(0));
      check("rst_none", 32'(bus.none), 32'(0));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.D         = '0;
      bus.out_ready = 1'b0;
      #2;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Full drain
      step(1'b1, 4'b1011, 1'b1);
      drain();
      // Backpressure: first index held for three cycles
      step(1'b1, 4'b0110, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
      drain();
      // Zero vector
      step(1'b1, 4'b0000, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      // Single bit, with a competing vector offered during DRAIN
      step(1'b1, 4'b1000, 1'b0);
      step(1'b1, 4'b0101, 1'b0);
      step(1'b1, 4'b0101, 1'b0);
      step(1'b0, '0, 1'b1);
      drain();
      // Reset mid-drain
      step(1'b1, 4'b1011, 1'b0);
      step(1'b0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      exp_none = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) step(1'b0, '0, 1'b1);
      // Randomized traffic
      repeat (400) begin
         step(1'($urandom % 2), N'($urandom), ($urandom % 4) != 0);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
